// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op encodings,
// vector defaults and the alignment helper used by the target path.
package pc_seq_pkg;

   localparam int PC_OP_W = 4;

   // NEXT/BZ/BG keep their legacy values; the rest extend the space upward.
   typedef enum logic [PC_OP_W-1:0] {
      PC_OP_NEXT = 4'd0,
      PC_OP_BZ   = 4'd1,
      PC_OP_BG   = 4'd2,
      PC_OP_J    = 4'd3,
      PC_OP_JAL  = 4'd4,
      PC_OP_JR   = 4'd5,
      PC_OP_RET  = 4'd6,
      PC_OP_EXC  = 4'd7,
      PC_OP_ERET = 4'd8
   } pc_op_e;

   localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_3000;
   localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_4180;
   localparam int          PC_RAS_DEPTH_DEF = 4;

   function automatic logic pc_misaligned(input logic [1:0] i_lsb);
      return i_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty is ignored. o_top reads 0 when the stack is empty.
module pc_ras #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_top,
   output logic         o_empty,
   output logic         o_full
);

   localparam int             PW       = $clog2(DEPTH);
   localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_ptr;
   logic [PW:0]   r_count;
   logic [PW-1:0] w_ptr_inc;
   logic [PW-1:0] w_ptr_dec;

   // Pointer arithmetic wraps naturally because DEPTH is a power of two.
   assign w_ptr_inc = r_ptr + 1'b1;
   assign w_ptr_dec = r_ptr - 1'b1;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_top   = o_empty ? '0 : r_mem[r_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_push) begin
         r_ptr            <= w_ptr_inc;
         r_mem[w_ptr_inc] <= i_data;
         if (!o_full) begin
            r_count <= r_count + 1'b1;
         end
      end else if (i_pop && !o_empty) begin
         r_ptr   <= w_ptr_dec;
         r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: fetch address register, next-PC target mux,
// EPC, return-address stack and misaligned-target trapping.
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC_DEF),
   parameter int                RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rest_n,
   input  logic [3:0]        pc_op,
   input  logic              zero,
   input  logic              great,
   input  logic [15:0]       im1,
   input  logic [25:0]       im2,
   input  logic [ADDR_W-1:0] j_reg,
   input  logic [ADDR_W-1:0] cop_addr,
   input  logic              stall,
   input  logic              fetch_ready,
   output logic              fetch_valid,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] rt_addr,
   output logic [ADDR_W-1:0] epc,
   output logic [ADDR_W-1:0] ras_top,
   output logic              ras_miss,
   output logic              adel
);

   // Wide scratch width so the J-target splice works for any ADDR_W >= 8.
   localparam int XW = (ADDR_W > 32) ? ADDR_W : 32;

   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_epc;
   logic              r_fetch_valid;
   logic              r_ras_miss;
   logic              r_adel;

   pc_op_e            w_op;
   logic              w_step;
   logic [ADDR_W-1:0] w_seq;
   logic [ADDR_W-1:0] w_br;
   logic [ADDR_W-1:0] w_jtgt;
   logic [XW-1:0]     w_pc_x;
   logic [XW-1:0]     w_j_x;
   logic [XW-1:0]     w_off_x;
   logic [ADDR_W-1:0] w_target;
   logic              w_push;
   logic              w_pop;
   logic              w_miss;
   logic              w_save_epc;
   logic              w_misalign;
   logic [ADDR_W-1:0] w_ras_top;
   logic              w_ras_empty;
   logic              w_unused_ras_full;

   assign w_op = pc_op_e'(pc_op);

   // fetch_valid / fetch_ready / ~stall is the normal advance; EXC only
   // needs a valid fetch address and bypasses stall and fetch_ready.
   assign w_step = r_fetch_valid &
                   ((w_op == PC_OP_EXC) | (fetch_ready & ~stall));

   assign w_seq   = r_addr + ADDR_W'(4);
   assign w_off_x = {{(XW-18){im1[15]}}, im1, 2'b00};
   assign w_br    = w_seq + w_off_x[ADDR_W-1:0];
   assign w_pc_x  = XW'(r_addr);
   assign w_j_x   = {w_pc_x[XW-1:28], im2, 2'b00};
   assign w_jtgt  = w_j_x[ADDR_W-1:0];

   always_comb begin
      w_target   = w_seq;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_miss     = 1'b0;
      w_save_epc = 1'b0;
      case (w_op)
         PC_OP_BZ:   if (zero)  w_target = w_br;
         PC_OP_BG:   if (great) w_target = w_br;
         PC_OP_J:    w_target = w_jtgt;
         PC_OP_JAL: begin
            w_target = w_jtgt;
            w_push   = 1'b1;
         end
         PC_OP_JR:   w_target = j_reg;
         PC_OP_RET: begin
            w_target = j_reg;
            w_pop    = 1'b1;
            w_miss   = w_ras_empty | (w_ras_top != j_reg);
         end
         PC_OP_EXC: begin
            w_target   = cop_addr;
            w_save_epc = 1'b1;
         end
         PC_OP_ERET: w_target = r_epc;
         default:    w_target = w_seq;
      endcase
   end

   assign w_misalign = pc_misaligned(w_target[1:0]);

   always_ff @(posedge clk or negedge rest_n) begin
      if (!rest_n) begin
         r_addr        <= RESET_VEC;
         r_epc         <= '0;
         r_fetch_valid <= 1'b0;
         r_ras_miss    <= 1'b0;
         r_adel        <= 1'b0;
      end else begin
         r_fetch_valid <= 1'b1;
         r_ras_miss    <= w_step & w_miss;
         r_adel        <= w_step & w_misalign;
         if (w_step) begin
            // A misaligned target traps; EPC records the bad target itself.
            if (w_misalign) begin
               r_addr <= EXC_VEC;
               r_epc  <= w_target;
            end else begin
               r_addr <= w_target;
               if (w_save_epc) begin
                  r_epc <= r_addr;
               end
            end
         end
      end
   end

   pc_ras #(
      .DEPTH (RAS_DEPTH),
      .W     (ADDR_W)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rest_n),
      .i_push  (w_step & w_push),
      .i_pop   (w_step & w_pop),
      .i_data  (rt_addr),
      .o_top   (w_ras_top),
      .o_empty (w_ras_empty),
      .o_full  (w_unused_ras_full)
   );

   assign fetch_valid = r_fetch_valid;
   assign addr        = r_addr;
   assign rt_addr     = w_seq;
   assign epc         = r_epc;
   assign ras_top     = w_ras_top;
   assign ras_miss    = r_ras_miss;
   assign adel        = r_adel;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed flows followed by randomized ops,
// all compared against a queue-based behavioural model.
module tb_pc_seq;
   import pc_seq_pkg::*;

   localparam int          AW    = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RST_V = 32'h0000_3000;
   localparam logic [31:0] EXC_V = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        rest_n = 1'b0;
   logic [3:0]  pc_op = 4'd0;
   logic        zero = 1'b0;
   logic        great = 1'b0;
   logic [15:0] im1 = '0;
   logic [25:0] im2 = '0;
   logic [31:0] j_reg = '0;
   logic [31:0] cop_addr = '0;
   logic        stall = 1'b0;
   logic        fetch_ready = 1'b0;
   logic        fetch_valid;
   logic [31:0] addr;
   logic [31:0] rt_addr;
   logic [31:0] epc;
   logic [31:0] ras_top;
   logic        ras_miss;
   logic        adel;

   always #5 clk = ~clk;

   pc_seq #(
      .ADDR_W    (AW),
      .RESET_VEC (RST_V),
      .EXC_VEC   (EXC_V),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rest_n      (rest_n),
      .pc_op       (pc_op),
      .zero        (zero),
      .great       (great),
      .im1         (im1),
      .im2         (im2),
      .j_reg       (j_reg),
      .cop_addr    (cop_addr),
      .stall       (stall),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .addr        (addr),
      .rt_addr     (rt_addr),
      .epc         (epc),
      .ras_top     (ras_top),
      .ras_miss    (ras_miss),
      .adel        (adel)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state; the RAS is a plain queue, newest at the back.
   logic [31:0] m_addr;
   logic [31:0] m_epc;
   logic        m_valid;
   logic        m_miss;
   logic        m_adel;
   logic [31:0] m_ras[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      logic [31:0] exp_top;
      exp_top = (m_ras.size() > 0) ? m_ras[$] : 32'd0;
      check({ctx, ".addr"},        addr,    m_addr);
      check({ctx, ".epc"},         epc,     m_epc);
      check({ctx, ".rt_addr"},     rt_addr, m_addr + 32'd4);
      check({ctx, ".ras_top"},     ras_top, exp_top);
      check({ctx, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, m_valid});
      check({ctx, ".ras_miss"},    {31'd0, ras_miss},    {31'd0, m_miss});
      check({ctx, ".adel"},        {31'd0, adel},        {31'd0, m_adel});
   endtask

   task automatic model_reset();
      m_addr  = RST_V;
      m_epc   = 32'd0;
      m_valid = 1'b0;
      m_miss  = 1'b0;
      m_adel  = 1'b0;
      m_ras.delete();
   endtask

   // Applies the effect of one rising edge using the inputs currently driven.
   task automatic model_edge();
      logic [31:0] seq;
      logic [31:0] tgt;
      logic        save;
      int          off;
      if (!rest_n) return;
      m_miss = 1'b0;
      m_adel = 1'b0;
      if (m_valid && (pc_op == PC_OP_EXC || (fetch_ready && !stall))) begin
         seq  = m_addr + 32'd4;
         tgt  = seq;
         save = 1'b0;
         off  = $signed(im1);
         case (pc_op)
            PC_OP_BZ:  if (zero)  tgt = seq + 32'(off * 4);
            PC_OP_BG:  if (great) tgt = seq + 32'(off * 4);
            PC_OP_J:   tgt = (m_addr & 32'hF000_0000) | (32'(im2) << 2);
            PC_OP_JAL: begin
               tgt = (m_addr & 32'hF000_0000) | (32'(im2) << 2);
               m_ras.push_back(seq);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            PC_OP_JR:  tgt = j_reg;
            PC_OP_RET: begin
               tgt = j_reg;
               if (m_ras.size() == 0) m_miss = 1'b1;
               else begin
                  if (m_ras[$] != j_reg) m_miss = 1'b1;
                  void'(m_ras.pop_back());
               end
            end
            PC_OP_EXC: begin
               tgt  = cop_addr;
               save = 1'b1;
            end
            PC_OP_ERET: tgt = m_epc;
            default:    tgt = seq;
         endcase
         if (tgt % 4 != 0) begin
            m_epc  = tgt;
            m_addr = EXC_V;
            m_adel = 1'b1;
         end else begin
            if (save) m_epc = m_addr;
            m_addr = tgt;
         end
      end
      m_valid = 1'b1;
   endtask

   task automatic cycle(input string ctx, input logic [3:0] op, input logic z, input logic g,
                        input logic [15:0] i1, input logic [25:0] i2, input logic [31:0] jr,
                        input logic [31:0] cp, input logic stl, input logic rdy);
      pc_op       = op;
      zero        = z;
      great       = g;
      im1         = i1;
      im2         = i2;
      j_reg       = jr;
      cop_addr    = cp;
      stall       = stl;
      fetch_ready = rdy;
      model_edge();
      @(posedge clk);
      #1;
      check_all(ctx);
   endtask

   task automatic op_simple(input string ctx, input logic [3:0] op, input logic [31:0] jr);
      cycle(ctx, op, 1'b0, 1'b0, 16'd0, 26'd0, jr, 32'd0, 1'b0, 1'b1);
   endtask

   logic [31:0] links[4];

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rest_n = 1'b1;

      // First edge after reset only raises fetch_valid.
      op_simple("first", PC_OP_NEXT, 32'd0);
      for (int i = 0; i < 3; i++) op_simple("next", PC_OP_NEXT, 32'd0);
      check("next3.addr_const", addr, 32'h0000_300C);

      cycle("bz_stall", PC_OP_BZ, 1'b1, 1'b0, 16'hFFFE, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      cycle("bz_stall", PC_OP_BZ, 1'b1, 1'b0, 16'hFFFE, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      cycle("bz_taken", PC_OP_BZ, 1'b1, 1'b0, 16'hFFFE, 26'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check("bz.addr_const", addr, 32'h0000_3008);
      cycle("bg_ntaken", PC_OP_BG, 1'b1, 1'b0, 16'h0010, 26'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check("bg.addr_const", addr, 32'h0000_300C);
      cycle("not_ready", PC_OP_JR, 1'b0, 1'b0, 16'd0, 26'd0, 32'h40, 32'd0, 1'b0, 1'b0);

      op_simple("jr", PC_OP_JR, 32'h0000_3000);
      cycle("jal", PC_OP_JAL, 1'b0, 1'b0, 16'd0, 26'h0000C00, 32'd0, 32'd0, 1'b0, 1'b1);
      check("jal.top_const", ras_top, 32'h0000_3004);
      op_simple("ret_hit", PC_OP_RET, 32'h0000_3004);
      op_simple("ret_bad", PC_OP_RET, 32'h0000_0007);
      check("ret_bad.epc_const", epc, 32'h0000_0007);
      check("ret_bad.addr_const", addr, EXC_V);

      op_simple("jr", PC_OP_JR, 32'h0000_3000);
      for (int k = 0; k < 5; k++)
         cycle("jal5", PC_OP_JAL, 1'b0, 1'b0, 16'd0, 26'h0000C00 + 26'(k), 32'd0, 32'd0, 1'b0, 1'b1);
      links = '{32'h3010, 32'h300C, 32'h3008, 32'h3004};
      for (int k = 0; k < 4; k++) op_simple("pop", PC_OP_RET, links[k]);
      op_simple("pop5", PC_OP_RET, 32'h0000_3000);
      check("pop5.miss_const", {31'd0, ras_miss}, 32'd1);

      op_simple("next", PC_OP_NEXT, 32'd0);
      cycle("exc", PC_OP_EXC, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0, 32'h0000_3000, 1'b1, 1'b0);
      op_simple("eret", PC_OP_ERET, 32'd0);

      op_simple("wrap_jr", PC_OP_JR, 32'hFFFF_FFFC);
      op_simple("wrap_next", PC_OP_NEXT, 32'd0);
      op_simple("undef", 4'hF, 32'd0);

      // Reset in the middle of a stalled JAL clears everything at once.
      op_simple("jr", PC_OP_JR, 32'h0000_3000);
      cycle("jal_pre", PC_OP_JAL, 1'b0, 1'b0, 16'd0, 26'h0000C40, 32'd0, 32'd0, 1'b0, 1'b1);
      cycle("jal_stall", PC_OP_JAL, 1'b0, 1'b0, 16'd0, 26'h0000C80, 32'd0, 32'd0, 1'b1, 1'b1);
      #2;
      rest_n = 1'b0;
      model_reset();
      #1;
      check_all("mid_reset");
      cycle("held_reset", PC_OP_JAL, 1'b0, 1'b0, 16'd0, 26'h0000C80, 32'd0, 32'd0, 1'b0, 1'b1);
      rest_n = 1'b1;
      cycle("post_reset", PC_OP_JAL, 1'b0, 1'b0, 16'd0, 26'h0000C80, 32'd0, 32'd0, 1'b0, 1'b1);
      check("post_reset.top_const", ras_top, 32'd0);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] jr;
         logic [31:0] cp;
         jr = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) jr = $urandom;
         if (m_ras.size() > 0 && $urandom_range(0, 1) == 1) jr = m_ras[$];
         cp = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) cp = $urandom;
         cycle("rand", 4'($urandom_range(0, 9)), 1'($urandom), 1'($urandom),
               16'($urandom), 26'($urandom), jr, cp,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the MIPS core; successor to the single-width `pc` block. It holds the fetch address, computes next-PC for sequential, branch, jump, register-jump, exception and return flows, and gates PC update with a fetch handshake and pipeline stall. It adds an EPC register for exception return, a return-address stack (RAS) with mispredict reporting, and automatic misaligned-target trapping. It sits between the decoder/control unit and the instruction memory port.

## Interface
- `ADDR_W`, 32: PC width (≥ 8).
- `RESET_VEC`, 32'h0000_3000: PC after reset.
- `EXC_VEC`, 32'h0000_4180: exception / misalign handler address.
- `RAS_DEPTH`, 4: RAS entries (power of two, ≥ 2).

- `clk`  in  1  clock, rising edge.
- `rest_n`  in  1  asynchronous active-low reset.
- `pc_op`  in  4  operation code, `PC_OP_*`.
- `zero`  in  1  ALU zero flag.
- `great`  in  1  ALU greater-than flag.
- `im1`  in  16  branch offset, in words, signed.
- `im2`  in  26  jump index.
- `j_reg`  in  ADDR_W  register jump target.
- `cop_addr`  in  ADDR_W  coprocessor redirect target.
- `stall`  in  1  pipeline hold.
- `fetch_ready`  in  1  imem accepted `addr`.
- `fetch_valid`  out  1  `addr` is valid for fetch.
- `addr`  out  ADDR_W  current PC.
- `rt_addr`  out  ADDR_W  link address, `addr + 4`, combinational.
- `epc`  out  ADDR_W  saved exception PC.
- `ras_top`  out  ADDR_W  RAS top, or 0 when empty.
- `ras_miss`  out  1  one-cycle pulse on RAS mispredict.
- `adel`  out  1  one-cycle pulse on misaligned target trap.

## Operation
- Ops: NEXT `addr+4`; BZ, taken if `zero`; BG, taken if `great`. The branch target is `addr + 4 + (sext(im1) << 2)`. A not-taken branch goes to `addr + 4`.
- J targets `{addr[ADDR_W-1:28], im2, 2'b00}`. When `ADDR_W` < 32, truncate to `ADDR_W`.
- JAL: same target as J, and pushes `rt_addr` onto the RAS.
- JR: target `j_reg`. The RAS is untouched.
- RET: target `j_reg`. Pops the RAS. Pulses `ras_miss` if the RAS was empty or `ras_top != j_reg`.
- EXC: saves `addr` into `epc` and targets `cop_addr`.
- ERET: targets `epc`.
- Undefined codes behave as NEXT.
- Advance condition `adv = fetch_valid & fetch_ready & ~stall`. EXC overrides `stall` and `fetch_ready`. Otherwise, when `adv` is 0, `addr`, RAS and `epc` hold and `pc_op` is ignored.
- Misalign: if an advancing target has `[1:0] != 0`, then `addr` is set to `EXC_VEC`, `epc` is set to the faulting target, and `adel` pulses. Any RAS push/pop for that op still occurs.
- RAS is circular. A push when full overwrites the oldest entry; the count saturates at `RAS_DEPTH`. A pop when empty leaves the count at 0.

## Timing
- Reset, asynchronous: `addr = RESET_VEC`, `epc = 0`, RAS empty, `fetch_valid = 0`, `ras_miss = adel = 0`.
- `fetch_valid` rises on the first rising edge after `rest_n` deasserts, and stays 1 thereafter.
- An op is sampled at the rising edge where `adv` or EXC holds. The new `addr` is visible after that edge, so latency is 1 cycle.
- `ras_miss` and `adel` are registered. Each is high for exactly the cycle following the causing edge.
- `rt_addr` and `ras_top` are combinational from registered state.
- Reset asserted mid-operation clears everything immediately. No pending op survives.
- Arithmetic is modulo 2^ADDR_W. `addr+4` at the all-ones boundary wraps to 0.

## Structure
- `PC_OP_*` encodings go in the shared `common.v`. Existing codes (NEXT, BZ, BG) keep their values; add J, JAL, JR, RET, EXC, ERET.
- Vector defaults also go in `common.v`.
- One sub-module, `pc_ras`: parameterised circular stack with push, pop, top, empty and full.
- Target mux and misalign check stay in `pc_seq`.

## Test plan
- Reset, then NEXT ×3 with `fetch_ready=1`: `addr` goes 3000 → 3004 → 3008 → 300C. `fetch_valid` is 0 during reset.
- At 300C, BZ with `zero=1` and `im1=16'hFFFE` gives 3008. BG with `great=0` gives 300C. A stall during BZ holds `addr` for the stall cycles.
- JAL with `im2=26'h0000C00` at 3000 gives 3000 and RAS top 3004. RET with `j_reg=3004` gives 3004 with no `ras_miss`. RET with `j_reg=7`, RAS empty: `ras_miss` pulses, then `adel` pulses and `addr=EXC_VEC`, `epc=7`.
- Five JALs into a depth-4 RAS: 4 pops return the last four links in LIFO order, and a fifth pop flags `ras_miss`.
- EXC with `cop_addr=3000`, `stall=1`, `fetch_ready=0`: `addr=3000` and `epc` holds the prior PC. ERET returns there.
- Assert `rest_n=0` mid-stall with a pending JAL: `addr=RESET_VEC` immediately, RAS empty, and no push occurs.
